// File: rtl/nbj_pkg.sv
// Shared definitions for the non-branch-jump correction queue.
// Packet layout inside one channel slice (E = 1 + IDX_W + PC_W bits):
//   [0 +: PC_W]      corrected PC
//   [PC_W +: IDX_W]  fetch-slot index
//   [E-1]            error type
// nbj_corr_t is sized for the widest supported configuration so a single
// typedef serves every parameterisation; callers take the low bits they need.
package nbj_pkg;

    localparam int NBJ_PC_W_MAX  = 64;
    localparam int NBJ_IDX_W_MAX = 8;
    localparam int NBJ_PKT_W_MAX = 1 + NBJ_IDX_W_MAX + NBJ_PC_W_MAX;

    typedef struct packed {
        logic                     errType;
        logic [NBJ_IDX_W_MAX-1:0] index;
        logic [NBJ_PC_W_MAX-1:0]  pc;
    } nbj_corr_t;

    function automatic int nbj_pkt_w(input int pc_w, input int idx_w);
        return 1 + idx_w + pc_w;
    endfunction

    function automatic int nbj_idx_off(input int pc_w);
        return pc_w;
    endfunction

    function automatic int nbj_err_off(input int pc_w, input int idx_w);
        return pc_w + idx_w;
    endfunction

    // Unpack a zero-extended packet slice into its fields.
    function automatic nbj_corr_t nbj_unpack(input logic [NBJ_PKT_W_MAX-1:0] slice,
                                             input int pc_w, input int idx_w);
        nbj_corr_t r;
        r = '0;
        for (int b = 0; b < NBJ_PC_W_MAX; b++) begin
            if (b < pc_w) r.pc[b] = slice[b];
        end
        for (int b = 0; b < NBJ_IDX_W_MAX; b++) begin
            if (b < idx_w) r.index[b] = slice[nbj_idx_off(pc_w) + b];
        end
        r.errType = slice[nbj_err_off(pc_w, idx_w)];
        return r;
    endfunction

endpackage

// File: rtl/nbj_rr_arb.sv
// NUM_CH-way round-robin arbiter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer -> 0)
//   en_i      - arbitration allowed this cycle; no grant when low
//   req_i     - per-channel request
//   grant_o   - one-hot grant (combinational), at most one bit set
// The search starts at the pointer and wraps; the pointer moves to one past
// the winner only when a grant is issued.
module nbj_rr_arb #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] grant_o
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(ptr_q) + i) % NUM_CH;
            if (en_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = PW'((idx + 1) % NUM_CH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/nbj_correct_queue.sv
// Multi-channel PC-correction queue: round-robin accepts correction packets
// from NUM_CH channels into a DEPTH-entry FIFO and presents the head to the
// fetch redirect logic over valid/ready.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   i_valid, i_data     - per-channel packet valid and packed packets
//   o_grant             - one-hot accept this cycle (combinational)
//   i_flush             - discard everything queued
//   o_valid, i_ready    - head handshake
//   o_errType, o_correctPcIndex, o_correctPc - head fields (0 when empty)
//   o_count             - occupancy
//   o_errCnt, o_okCnt   - dequeue statistics, only with NBJ_CORRECT_STATS_EN
// Optional feature macro: NBJ_CORRECT_STATS_EN
module nbj_correct_queue
    import nbj_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int PC_W   = 32,
    parameter int IDX_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CH-1:0]                 i_valid,
    input  logic [NUM_CH*(1+IDX_W+PC_W)-1:0]  i_data,
    output logic [NUM_CH-1:0]                 o_grant,
    input  logic                              i_flush,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic                              o_errType,
    output logic [IDX_W-1:0]                  o_correctPcIndex,
    output logic [PC_W-1:0]                   o_correctPc,
    output logic [$clog2(DEPTH):0]            o_count
`ifdef NBJ_CORRECT_STATS_EN
    ,
    output logic [15:0]                       o_errCnt,
    output logic [15:0]                       o_okCnt
`endif
);
    localparam int E  = nbj_pkt_w(PC_W, IDX_W);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [E-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [E-1:0]    ch_pkt [NUM_CH];
    logic [E-1:0]    wr_pkt;
    logic            arb_en, push, pop, not_empty;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_pkt[gi] = i_data[gi*E +: E];
        end
    endgenerate

    // No grant while full, even if the head leaves this cycle, so the
    // accept decision never depends on i_ready.
    assign arb_en    = !rst && !i_flush && (count_q != FULL_CNT);
    assign not_empty = (count_q != '0);
    assign push      = |o_grant;
    assign pop       = not_empty && i_ready;

    nbj_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en_i    (arb_en),
        .req_i   (i_valid),
        .grant_o (o_grant)
    );

    always_comb begin
        wr_pkt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (o_grant[c]) wr_pkt = ch_pkt[c];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: push is forced low during reset and flush.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_pkt;
    end

    // Head decode; entries are registered so outputs have no path from i_*.
    logic [NBJ_PKT_W_MAX-1:0] head_raw;
    nbj_corr_t                head_s;
    logic                     head_unused;

    always_comb begin
        head_raw        = '0;
        head_raw[E-1:0] = mem_q[rd_ptr_q];
    end

    assign head_s      = nbj_unpack(head_raw, PC_W, IDX_W);
    assign head_unused = ^{head_s.pc, head_s.index};

    assign o_valid          = not_empty;
    assign o_errType        = not_empty ? head_s.errType : 1'b0;
    assign o_correctPcIndex = not_empty ? head_s.index[IDX_W-1:0] : '0;
    assign o_correctPc      = not_empty ? head_s.pc[PC_W-1:0] : '0;
    assign o_count          = count_q;

`ifdef NBJ_CORRECT_STATS_EN
    // A pop coinciding with a flush is a real handshake and is counted.
    logic [15:0] err_cnt_q, ok_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            ok_cnt_q  <= '0;
        end else if (pop) begin
            if (o_errType) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
                if (ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
            end
        end
    end

    assign o_errCnt = err_cnt_q;
    assign o_okCnt  = ok_cnt_q;
`endif

endmodule

// File: tb/tb_nbj_correct_queue.sv
module tb_nbj_correct_queue;
    localparam int NUM_CH = 2;
    localparam int PC_W   = 32;
    localparam int IDX_W  = 3;
    localparam int DEPTH  = 4;
    localparam int E      = 1 + IDX_W + PC_W;

    typedef struct {
        logic             err;
        logic [IDX_W-1:0] idx;
        logic [PC_W-1:0]  pc;
    } pkt_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_CH-1:0]      i_valid;
    logic [NUM_CH*E-1:0]    i_data;
    logic [NUM_CH-1:0]      o_grant;
    logic                   i_flush;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_errType;
    logic [IDX_W-1:0]       o_correctPcIndex;
    logic [PC_W-1:0]        o_correctPc;
    logic [$clog2(DEPTH):0] o_count;
`ifdef NBJ_CORRECT_STATS_EN
    logic [15:0]            o_errCnt, o_okCnt;
    int                     err_m = 0, ok_m = 0;
`endif

    always #5 clk = ~clk;

    nbj_correct_queue #(.NUM_CH(NUM_CH), .PC_W(PC_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_valid          (i_valid),
        .i_data           (i_data),
        .o_grant          (o_grant),
        .i_flush          (i_flush),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_errType        (o_errType),
        .o_correctPcIndex (o_correctPcIndex),
        .o_correctPc      (o_correctPc),
        .o_count          (o_count)
`ifdef NBJ_CORRECT_STATS_EN
        ,
        .o_errCnt         (o_errCnt),
        .o_okCnt          (o_okCnt)
`endif
    );

    int   checks = 0;
    int   passed = 0;
    pkt_t sbq[$];
    int   rr_m   = 0;
    bit   known  = 1'b0;
    int   cyc    = 0;

    function automatic pkt_t mk(input logic e, input logic [IDX_W-1:0] x, input logic [PC_W-1:0] p);
        pkt_t r;
        r.err = e; r.idx = x; r.pc = p;
        return r;
    endfunction

    function automatic logic [E-1:0] pack(input pkt_t p);
        return {p.err, p.idx, p.pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // One clock cycle: drive inputs, check head state and the combinational
    // grant against the scoreboard model, then advance the model and clock.
    task automatic cycle(input logic [1:0] v, input pkt_t p0, input pkt_t p1,
                         input logic fl, input logic rdy, input logic rs);
        logic [NUM_CH-1:0] eg;
        int                win;
        bit                exp_valid;
        pkt_t              gp;
        rst     = rs;
        i_valid = v;
        i_data  = {pack(p1), pack(p0)};
        i_flush = fl;
        i_ready = rdy;
        #1;
        exp_valid = (sbq.size() != 0);
        if (known) begin
            chk("valid", o_valid, exp_valid);
            chk("count", o_count, sbq.size());
            if (exp_valid) begin
                chk("pc",  o_correctPc, sbq[0].pc);
                chk("idx", o_correctPcIndex, sbq[0].idx);
                chk("err", o_errType, sbq[0].err);
            end else begin
                chk("pc_empty",  o_correctPc, 0);
                chk("idx_empty", o_correctPcIndex, 0);
                chk("err_empty", o_errType, 0);
            end
`ifdef NBJ_CORRECT_STATS_EN
            chk("errCnt", o_errCnt, err_m);
            chk("okCnt",  o_okCnt,  ok_m);
`endif
        end
        eg  = '0;
        win = -1;
        if (!rs && !fl && sbq.size() < DEPTH) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = (rr_m + i) % NUM_CH;
                if (win < 0 && v[c]) win = c;
            end
        end
        if (win >= 0) eg[win] = 1'b1;
        chk("grant", o_grant, eg);
        $display("cyc %0d rst=%0b v=%b fl=%0b rdy=%0b grant=%b valid=%0b pc=%h count=%0d",
                 cyc, rs, v, fl, rdy, o_grant, o_valid, o_correctPc, o_count);
        if (rs) begin
            sbq.delete();
            rr_m = 0;
`ifdef NBJ_CORRECT_STATS_EN
            err_m = 0; ok_m = 0;
`endif
        end else begin
`ifdef NBJ_CORRECT_STATS_EN
            if (exp_valid && rdy) begin
                if (sbq[0].err) begin if (err_m < 16'hFFFF) err_m++; end
                else begin if (ok_m < 16'hFFFF) ok_m++; end
            end
`endif
            if (fl) sbq.delete();
            else begin
                if (exp_valid && rdy) void'(sbq.pop_front());
                if (win >= 0) begin
                    gp = (win == 0) ? p0 : p1;
                    sbq.push_back(gp);
                    rr_m = (win + 1) % NUM_CH;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rs) known = 1'b1;
    endtask

    pkt_t z, a, b;

    initial begin
        z = mk(1'b0, '0, '0);

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            cycle(2'($urandom), mk(1'($urandom), 3'($urandom), $urandom),
                  mk(1'($urandom), 3'($urandom), $urandom), 1'($urandom), 1'($urandom), 1'b1);
        cycle(2'b00, z, z, 1'b0, 1'b0, 1'b0);

        // Single packet on ch0
        cycle(2'b01, mk(1'b1, 3'd5, 32'h0000_1040), z, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, z, z, 1'b0, 1'b1, 1'b0);
        cycle(2'b00, z, z, 1'b0, 1'b0, 1'b0);

        // Round robin: both channels valid, ready high
        for (int i = 0; i < 6; i++)
            cycle(2'b11, mk(1'b0, 3'(i), 32'hA000 + i), mk(1'b1, 3'(7 - i), 32'hB000 + i),
                  1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(2'b00, z, z, 1'b0, 1'b1, 1'b0);

        // Full: ch0 streams 5 packets with ready low, then ready rises
        for (int i = 0; i < 5; i++)
            cycle(2'b01, mk(1'(i), 3'(i), 32'hC000 + i), z, 1'b0, 1'b0, 1'b0);
        a = mk(1'b0, 3'd4, 32'hC004);
        cycle(2'b01, a, z, 1'b0, 1'b0, 1'b0);   // still full, held
        cycle(2'b01, a, z, 1'b0, 1'b1, 1'b0);   // ready rises: still no grant
        cycle(2'b01, a, z, 1'b0, 1'b1, 1'b0);   // accepted now
        for (int i = 0; i < 5; i++) cycle(2'b00, z, z, 1'b0, 1'b1, 1'b0);

        // Flush: three queued, flush with ch1 valid and ready high
        for (int i = 0; i < 3; i++)
            cycle(2'b01, mk(1'b1, 3'(i), 32'hD000 + i), z, 1'b0, 1'b0, 1'b0);
        b = mk(1'b1, 3'd6, 32'hE0E0);
        cycle(2'b10, z, b, 1'b1, 1'b1, 1'b0);
        cycle(2'b10, z, b, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, z, z, 1'b0, 1'b1, 1'b0);
        cycle(2'b00, z, z, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation
        cycle(2'b11, mk(1'b1, 3'd1, 32'hF001), mk(1'b0, 3'd2, 32'hF002), 1'b0, 1'b0, 1'b0);
        cycle(2'b11, mk(1'b1, 3'd1, 32'hF001), mk(1'b0, 3'd2, 32'hF002), 1'b0, 1'b0, 1'b0);
        cycle(2'b11, mk(1'b1, 3'd3, 32'hF003), mk(1'b0, 3'd4, 32'hF004), 1'b0, 1'b1, 1'b1);
        cycle(2'b00, z, z, 1'b0, 1'b0, 1'b0);

`ifdef NBJ_CORRECT_STATS_EN
        cycle(2'b00, z, z, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(2'b01, mk((i < 3) ? 1'b1 : 1'b0, 3'(i), 32'h5000 + i), z, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(2'b00, z, z, 1'b0, 1'b1, 1'b0);
        chk("errCnt_3", o_errCnt, 16'd3);
        chk("okCnt_2",  o_okCnt,  16'd2);
        for (int i = 0; i < 65540; i++)
            cycle(2'b01, mk(1'b1, 3'd0, 32'h6000), z, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(2'b00, z, z, 1'b0, 1'b1, 1'b0);
        chk("errCnt_sat", o_errCnt, 16'hFFFF);
        chk("okCnt_hold", o_okCnt,  16'd2);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
